// File: rtl/pseudo_softmax_pkg.sv
// Shared types and helpers for the pseudo-softmax sequencer: state encoding,
// default sizing and the sum-to-operand saturation.
package pseudo_softmax_pkg;

    localparam int N_ELEM_DEF    = 4;
    localparam int DW_DEF        = 8;
    localparam int RECIP_LAT_DEF = 1;

    localparam int SUMW = DW_DEF + $clog2(N_ELEM_DEF);
    localparam int IDXW = $clog2(N_ELEM_DEF);
    localparam int CNTW = ($clog2(RECIP_LAT_DEF + 1) > 0) ? $clog2(RECIP_LAT_DEF + 1) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RECIP = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // Clamp x to the largest value representable in dw bits.
    function automatic logic [31:0] sat_dw(input logic [31:0] x, input int unsigned dw);
        logic [31:0] maxv;
        maxv = (32'd1 << dw) - 32'd1;
        return (x > maxv) ? maxv : x;
    endfunction

endpackage

// File: rtl/pseudo_softmax_ctrl_if.sv
// Handshake and reciprocal-unit signals of the pseudo-softmax sequencer.
// slave = the sequencer itself, master = its environment (streamer, sink, reciprocal unit).
interface pseudo_softmax_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] recip_in;
    logic [DW-1:0] recip_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    modport slave (
        input  in_valid, in_data, recip_out, out_ready,
        output in_ready, recip_in, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, recip_out, out_ready,
        input  in_ready, recip_in, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/pseudo_softmax_ctrl.sv
// Pseudo-softmax sequencer: buffers an N_ELEM vector while summing it, hands the
// saturated sum to an external reciprocal unit, then streams each element * reciprocal.
module pseudo_softmax_ctrl
    import pseudo_softmax_pkg::*;
#(
    parameter int N_ELEM    = 4,
    parameter int DW        = 8,
    parameter int RECIP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pseudo_softmax_ctrl_if.slave bus
);

    localparam int SUM_W = DW + $clog2(N_ELEM);
    localparam int IDX_W = $clog2(N_ELEM);
    localparam int CNT_W = (RECIP_LAT > 0) ? $clog2(RECIP_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(RECIP_LAT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     recip_q, recip_d;
    logic [DW-1:0]     r_q, r_d;
    logic [DW-1:0]     buf_q [N_ELEM];
    logic [DW-1:0]     buf_d [N_ELEM];

    logic              in_ready;
    logic              out_valid;
    logic              out_last;
    logic [SUM_W-1:0]  sum_nxt;
    logic [DW-1:0]     sum_sat;
    logic [2*DW-1:0]   prod;

    // The sum register is wide enough for N_ELEM full-scale elements, so it never wraps.
    assign sum_nxt = sum_q + SUM_W'(bus.in_data);
    assign sum_sat = DW'(sat_dw(32'(sum_nxt), DW));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        recip_d   = recip_q;
        r_d       = r_q;
        buf_d     = buf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = ~rst;
                if (bus.in_valid && in_ready) begin
                    buf_d[idx_q] = bus.in_data;
                    sum_d        = sum_nxt;
                    if (idx_q == IDX_LAST) begin
                        recip_d = sum_sat;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = RECIP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RECIP: begin
                // recip_in stays put; sample the unit once its pipeline has caught up.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_DONE) begin
                    r_d     = bus.recip_out;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (idx_q == IDX_LAST);
                if (bus.out_ready) begin
                    if (out_last) begin
                        sum_d   = '0;
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            recip_q <= '0;
            r_q     <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            recip_q <= recip_d;
            r_q     <= r_d;
            buf_q   <= buf_d;
        end
    end

    // Q0.DW reciprocal: keep the upper half of the product, truncating the fraction.
    assign prod = (2*DW)'(buf_q[idx_q]) * (2*DW)'(r_q);

    assign bus.in_ready  = in_ready;
    assign bus.recip_in  = recip_q;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_valid ? prod[2*DW-1:DW] : '0;
    assign bus.busy      = (state_q != LOAD);

endmodule

// File: tb/tb_pseudo_softmax_ctrl.sv
// Randomised self-checking bench for pseudo_softmax_ctrl with a registered reciprocal stub
// and a vector-level reference model.
module tb_pseudo_softmax_ctrl;

    localparam int N_ELEM    = 4;
    localparam int DW        = 8;
    localparam int RECIP_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pseudo_softmax_ctrl_if #(.DW(DW)) bus ();

    pseudo_softmax_ctrl #(
        .N_ELEM   (N_ELEM),
        .DW       (DW),
        .RECIP_LAT(RECIP_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reciprocal unit stand-in: constant stub or a coarse 255/x, RECIP_LAT registered stages.
    int            stub_mode = 0;
    logic [DW-1:0] stub_val  = 8'h80;

    function automatic logic [DW-1:0] recip_fn(input logic [DW-1:0] x);
        if (stub_mode == 0) return stub_val;
        if (x == '0) return 8'hFF;
        return 8'(255 / int'(x));
    endfunction

    logic [DW-1:0] rpipe [RECIP_LAT];
    always @(posedge clk) begin
        rpipe[0] <= recip_fn(bus.recip_in);
        for (int i = 1; i < RECIP_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.recip_out = rpipe[RECIP_LAT-1];

    // Downstream ready: fixed level or random.
    logic rdy_val  = 1'b1;
    logic rdy_rand = 1'b0;
    logic rnd_bit  = 1'b1;
    always @(posedge clk) begin
        #2;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end
    assign bus.out_ready = rdy_rand ? rnd_bit : rdy_val;

    // Reference model: collect accepted elements, predict the whole output vector.
    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic [DW-1:0] rin;
    } exp_t;

    exp_t exp_q[$];
    int   cur_q[$];
    int   got_q[$];
    exp_t m_e;
    int   m_sum, m_rin, m_r;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                cur_q.push_back(int'(bus.in_data));
                if (cur_q.size() == N_ELEM) begin
                    m_sum = 0;
                    for (int i = 0; i < N_ELEM; i++) m_sum += cur_q[i];
                    m_rin = (m_sum > 255) ? 255 : m_sum;
                    m_r   = int'(recip_fn(8'(m_rin)));
                    for (int i = 0; i < N_ELEM; i++) begin
                        m_e.d    = 8'((cur_q[i] * m_r) / 256);
                        m_e.last = (i == N_ELEM - 1);
                        m_e.rin  = 8'(m_rin);
                        exp_q.push_back(m_e);
                    end
                    cur_q.delete();
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(int'(bus.out_data));
                chk_eq("out_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    chk_eq("out_data", 32'(bus.out_data), 32'(m_e.d));
                    chk_eq("out_last", 32'(bus.out_last), 32'(m_e.last));
                    chk_eq("recip_in_at_out", 32'(bus.recip_in), 32'(m_e.rin));
                end
            end
        end
    end

    task automatic send_vec(input int v0, input int v1, input int v2, input int v3, input int gmax);
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            int g;
            repeat ($urandom_range(0, gmax)) begin
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(v[i]);
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!bus.in_ready && g < 300);
            if (g >= 300) chk_eq("in_accept_timeout", 32'(g), 0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus.busy) && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk_eq("drain_in_time", 32'(g < 500), 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_got(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk_eq({tag, "_count"}, 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk_eq($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(e[i]));
    endtask

    task automatic wait_out_valid();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.out_valid && g < 100);
        chk_eq("out_valid_seen", 32'(bus.out_valid), 1);
    endtask

    logic          t_ir [11];
    logic          t_ov [11];
    logic [DW-1:0] t_ri [11];

    initial begin
        int ni;
        logic hs;
        int tv[4];

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_in_ready",  32'(bus.in_ready), 0);
        chk_eq("rst_out_valid", 32'(bus.out_valid), 0);
        chk_eq("rst_out_last",  32'(bus.out_last), 0);
        chk_eq("rst_out_data",  32'(bus.out_data), 0);
        chk_eq("rst_busy",      32'(bus.busy), 0);
        chk_eq("rst_recip_in",  32'(bus.recip_in), 0);

        // Cycle-exact timing: release reset with in_valid already high (cycle 0).
        stub_mode = 0;
        stub_val  = 8'h80;
        tv = '{10, 20, 30, 40};
        ni = 0;
        got_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(tv[0]);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            t_ir[c] = bus.in_ready;
            t_ov[c] = bus.out_valid;
            t_ri[c] = bus.recip_in;
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs) begin
                ni++;
                if (ni < 4) bus.in_data = 8'(tv[ni]);
                else bus.in_valid = 1'b0;
            end
        end
        for (int c = 0; c <= 10; c++) begin
            chk_eq($sformatf("tim_in_ready_c%0d", c), 32'(t_ir[c]), 32'(c < 4 || c == 10));
            chk_eq($sformatf("tim_out_valid_c%0d", c), 32'(t_ov[c]), 32'(c >= 6 && c <= 9));
        end
        chk_eq("tim_recip_in_c4", 32'(t_ri[4]), 100);
        chk_eq("tim_recip_in_c5", 32'(t_ri[5]), 100);
        chk_got("tim_out", 5, 10, 15, 20);

        // Basic scaling with input gaps.
        got_q.delete();
        send_vec(10, 20, 30, 40, 2);
        drain();
        chk_eq("basic_recip_in", 32'(bus.recip_in), 100);
        chk_got("basic_out", 5, 10, 15, 20);

        // Saturated sum.
        stub_val = 8'h01;
        got_q.delete();
        send_vec(100, 100, 100, 100, 1);
        drain();
        chk_eq("sat_recip_in", 32'(bus.recip_in), 255);
        chk_got("sat_out", 0, 0, 0, 0);

        // Backpressure on the second output.
        stub_val = 8'h80;
        rdy_val  = 1'b0;
        got_q.delete();
        send_vec(10, 20, 30, 40, 0);
        wait_out_valid();
        @(posedge clk); #1;
        rdy_val = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rdy_val = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_eq("bp_out_data",  32'(bus.out_data), 10);
            chk_eq("bp_out_valid", 32'(bus.out_valid), 1);
            chk_eq("bp_out_last",  32'(bus.out_last), 0);
            chk_eq("bp_in_ready",  32'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        rdy_val = 1'b1;
        drain();
        chk_got("bp_out", 5, 10, 15, 20);

        // Reset in the middle of EMIT.
        rdy_val = 1'b0;
        send_vec(10, 20, 30, 40, 0);
        wait_out_valid();
        @(posedge clk); #1;
        rdy_val = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        cur_q.delete();
        #1;
        chk_eq("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk_eq("mid_rst_busy",      32'(bus.busy), 0);
        chk_eq("mid_rst_in_ready",  32'(bus.in_ready), 0);
        chk_eq("mid_rst_out_data",  32'(bus.out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        got_q.delete();
        send_vec(1, 1, 1, 1, 0);
        drain();
        chk_eq("post_rst_recip_in", 32'(bus.recip_in), 4);
        chk_got("post_rst_out", 0, 0, 0, 0);

        // All-zero vector, then a normal one.
        stub_val = 8'hFF;
        got_q.delete();
        send_vec(0, 0, 0, 0, 1);
        drain();
        chk_eq("zero_recip_in", 32'(bus.recip_in), 0);
        chk_got("zero_out", 0, 0, 0, 0);
        stub_val = 8'h80;
        got_q.delete();
        send_vec(10, 20, 30, 40, 1);
        drain();
        chk_got("after_zero_out", 5, 10, 15, 20);

        // Random vectors, random gaps and random downstream stalls.
        stub_mode = 1;
        rdy_rand  = 1'b1;
        for (int n = 0; n < 25; n++) begin
            int hi;
            hi = (n % 2 == 0) ? 255 : 70;
            send_vec($urandom_range(0, hi), $urandom_range(0, hi),
                     $urandom_range(0, hi), $urandom_range(0, hi), 3);
        end
        drain();
        rdy_rand = 1'b0;
        chk_eq("end_exp_empty", 32'(exp_q.size()), 0);
        chk_eq("end_partial_empty", 32'(cur_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
